// File: rtl/seg7_pkg.sv
// Purpose: shared segment codes and nibble-to-segment decode for the 7-segment scan driver.
// Segment vectors are abc_defg ordered: bit6 = a ... bit0 = g, active-high.
package seg7_pkg;

    localparam int unsigned SEG_W = 7;
    localparam int unsigned NIB_W = 4;

    typedef logic [SEG_W-1:0] seg_t;
    typedef logic [NIB_W-1:0] nib_t;

    localparam seg_t SEG_0     = 7'b111_1110;
    localparam seg_t SEG_1     = 7'b011_0000;
    localparam seg_t SEG_2     = 7'b110_1101;
    localparam seg_t SEG_3     = 7'b111_1001;
    localparam seg_t SEG_4     = 7'b011_0011;
    localparam seg_t SEG_5     = 7'b101_1011;
    localparam seg_t SEG_6     = 7'b101_1111;
    localparam seg_t SEG_7     = 7'b111_0000;
    localparam seg_t SEG_8     = 7'b111_1111;
    localparam seg_t SEG_9     = 7'b111_0011;
    localparam seg_t SEG_A     = 7'b111_0111;
    localparam seg_t SEG_B     = 7'b001_1111;
    localparam seg_t SEG_C     = 7'b100_1110;
    localparam seg_t SEG_D     = 7'b011_1101;
    localparam seg_t SEG_E     = 7'b100_1111;
    localparam seg_t SEG_F     = 7'b100_0111;
    localparam seg_t SEG_BLANK = 7'b000_0000;

    // Nibble to segments; letters A-F render blank unless hex_en is set.
    function automatic seg_t seg7_decode(input nib_t nib, input logic hex_en);
        seg_t s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = SEG_0;
            4'h1: s = SEG_1;
            4'h2: s = SEG_2;
            4'h3: s = SEG_3;
            4'h4: s = SEG_4;
            4'h5: s = SEG_5;
            4'h6: s = SEG_6;
            4'h7: s = SEG_7;
            4'h8: s = SEG_8;
            4'h9: s = SEG_9;
            4'hA: s = hex_en ? SEG_A : SEG_BLANK;
            4'hB: s = hex_en ? SEG_B : SEG_BLANK;
            4'hC: s = hex_en ? SEG_C : SEG_BLANK;
            4'hD: s = hex_en ? SEG_D : SEG_BLANK;
            4'hE: s = hex_en ? SEG_E : SEG_BLANK;
            default: s = hex_en ? SEG_F : SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_decode.sv
// Purpose: combinational nibble decoder wrapping the package decode function.
// Ports:
//   nib_i  in   4  digit nibble
//   seg_o  out  7  abc_defg segments, active-high (combinational)
module seg7_nibble_decode
    import seg7_pkg::*;
#(
    parameter bit HEX_MODE = 1'b0
) (
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = seg7_decode(nib_i, HEX_MODE);

endmodule

// File: rtl/seg7_scan_driver.sv
// Purpose: multiplexed N-digit 7-segment scan driver with frame-synchronous value
// updates, leading-zero blanking and optional active-low pin polarity.
// Ports:
//   clk       in   1             rising-edge clock
//   rst_n     in   1             synchronous active-low reset
//   load      in   1             capture din/dp_in into the pending register
//   din       in   4*NUM_DIGITS  packed nibbles, [3:0] = digit 0
//   dp_in     in   NUM_DIGITS    decimal point per digit
//   blank_lz  in   1             leading-zero blanking enable (live)
//   seg       out  7             abc_defg segments of the enabled digit
//   dp        out  1             decimal point of the enabled digit
//   an        out  NUM_DIGITS    one-hot digit enable
//   load_ack  out  1             one-cycle pulse when the pending value becomes visible
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned PRESCALE   = 1000,
    parameter bit          HEX_MODE   = 1'b0,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] din,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    load_ack
);

    localparam int unsigned DIN_W = NIB_W * NUM_DIGITS;
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    // Inactive (reset) levels of the pins; also the XOR mask applied to live values.
    localparam logic [SEG_W-1:0]      SEG_INV = {SEG_W{ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_INV  = {NUM_DIGITS{ACTIVE_LOW}};

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DIN_W-1:0]      disp_q, disp_d;
    logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
    logic [DIN_W-1:0]      pend_q, pend_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  ack_q, ack_d;

    logic                  pre_wrap;
    logic                  frame_end;
    logic                  xfer;
    logic [NIB_W-1:0]      cur_nib;
    logic                  cur_dp;
    logic                  cur_lz;
    logic [NUM_DIGITS-1:0] an_hot;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic [SEG_W-1:0]      dec_seg;

    seg7_nibble_decode #(
        .HEX_MODE (HEX_MODE)
    ) u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    // Digit select, one-hot enable and leading-zero detection from the display register.
    always_comb begin
        logic run_zero;
        cur_nib    = '0;
        cur_dp     = 1'b0;
        cur_lz     = 1'b0;
        an_hot     = '0;
        upper_zero = '0;
        run_zero   = 1'b1;
        // upper_zero[k]: nibbles k..N-1 are all zero
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            run_zero      = run_zero & (disp_q[NIB_W*k +: NIB_W] == '0);
            upper_zero[k] = run_zero;
        end
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = disp_q[NIB_W*k +: NIB_W];
                cur_dp    = disp_dp_q[k];
                cur_lz    = (k != 0) && upper_zero[k];
                an_hot[k] = 1'b1;
            end
        end
    end

    // Scan timing, frame-boundary transfer and next output values.
    always_comb begin
        pre_wrap   = (pre_q == PRE_W'(PRESCALE - 1));
        frame_end  = pre_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));
        xfer       = frame_end && pend_vld_q;

        pre_d      = pre_wrap ? '0 : pre_q + PRE_W'(1);
        idx_d      = idx_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end

        disp_d     = xfer ? pend_q    : disp_q;
        disp_dp_d  = xfer ? pend_dp_q : disp_dp_q;

        // A load in the transfer cycle lands in pending after the old value moved out.
        pend_d     = load ? din   : pend_q;
        pend_dp_d  = load ? dp_in : pend_dp_q;
        pend_vld_d = load | (pend_vld_q & ~xfer);

        seg_d      = ((blank_lz && cur_lz) ? SEG_BLANK : dec_seg) ^ SEG_INV;
        dp_d       = cur_dp ^ ACTIVE_LOW;
        an_d       = an_hot ^ AN_INV;
        ack_d      = xfer;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q      <= '0;
            idx_q      <= '0;
            disp_q     <= '0;
            disp_dp_q  <= '0;
            pend_q     <= '0;
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            seg_q      <= SEG_INV;
            dp_q       <= ACTIVE_LOW;
            an_q       <= AN_INV;
            ack_q      <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            pend_q     <= pend_d;
            pend_dp_q  <= pend_dp_d;
            pend_vld_q <= pend_vld_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            ack_q      <= ack_d;
        end
    end

    assign seg      = seg_q;
    assign dp       = dp_q;
    assign an       = an_q;
    assign load_ack = ack_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench: three driver instances (BCD, hex, hex+active-low) share one stimulus.
// n counts clock edges since reset release; samples are taken 1 time unit after the edge.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] din;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [6:0]  seg0, segh, segl;
    logic        dp0, dph, dpl;
    logic [3:0]  an0, anh, anl;
    logic        ack0, ackh, ackl;

    int n;
    int passed;
    int total;

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b0), .ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(seg0), .dp(dp0), .an(an0), .load_ack(ack0));

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b0)) dut_hex (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(segh), .dp(dph), .an(anh), .load_ack(ackh));

    seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(4), .HEX_MODE(1'b1), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din), .dp_in(dp_in), .blank_lz(blank_lz),
        .seg(segl), .dp(dpl), .an(anl), .load_ack(ackl));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic run_to(input int t);
        while (n < t) step();
    endtask

    initial begin
        n = 0; passed = 0; total = 0;
        rst_n = 1'b0; load = 1'b0; din = '0; dp_in = '0; blank_lz = 1'b0;

        // 1. reset state and scan sequence
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",     32'(an0),  32'h0);
        chk("rst_seg",    32'(seg0), 32'h00);
        chk("rst_ack",    32'(ack0), 32'h0);
        chk("rst_dp",     32'(dp0),  32'h0);
        chk("rst_al_an",  32'(anl),  32'hF);
        chk("rst_al_seg", 32'(segl), 32'h7F);
        chk("rst_al_dp",  32'(dpl),  32'h1);
        rst_n = 1'b1;
        step();
        chk("rel_an",     32'(an0),  32'h1);
        chk("rel_seg",    32'(seg0), 32'h7E);
        chk("rel_al_an",  32'(anl),  32'hE);
        chk("rel_al_seg", 32'(segl), 32'h01);
        run_to(4);
        chk("an_hold4",   32'(an0),  32'h1);
        run_to(5);
        chk("an_d1",      32'(an0),  32'h2);
        chk("seg_d1_0",   32'(seg0), 32'h7E);
        run_to(9);
        chk("an_d2",      32'(an0),  32'h4);
        run_to(13);
        chk("an_d3",      32'(an0),  32'h8);

        // 2. load 1234, one ack at the frame boundary
        din = 16'h1234; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        run_to(15);
        chk("ack_pre",    32'(ack0), 32'h0);
        run_to(16);
        chk("ack_1234",   32'(ack0), 32'h1);
        run_to(17);
        chk("ack_post",   32'(ack0), 32'h0);
        chk("d0_1234",    32'(seg0), 32'h33);
        chk("d0_an",      32'(an0),  32'h1);
        run_to(21);
        chk("d1_1234",    32'(seg0), 32'h79);
        run_to(25);
        chk("d2_1234",    32'(seg0), 32'h6D);
        run_to(29);
        chk("d3_1234",    32'(seg0), 32'h30);

        // 3. leading-zero blanking on 0070, dp on a blanked digit
        din = 16'h0070; dp_in = 4'b0100; blank_lz = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        run_to(32);
        chk("ack_0070",   32'(ack0), 32'h1);
        run_to(33);
        chk("lz_d0",      32'(seg0), 32'h7E);
        run_to(37);
        chk("lz_d1",      32'(seg0), 32'h70);
        chk("lz_d1_dp",   32'(dp0),  32'h0);
        run_to(41);
        chk("lz_d2",      32'(seg0), 32'h00);
        chk("lz_d2_an",   32'(an0),  32'h4);
        chk("lz_d2_dp",   32'(dp0),  32'h1);
        run_to(45);
        chk("lz_d3",      32'(seg0), 32'h00);
        chk("lz_d3_an",   32'(an0),  32'h8);
        blank_lz = 1'b0;
        step();
        chk("nolz_d3",    32'(seg0), 32'h7E);
        run_to(57);
        chk("nolz_d2",    32'(seg0), 32'h7E);
        chk("nolz_d2_dp", 32'(dp0),  32'h1);

        // 4. nibble A in BCD, hex and active-low instances
        din = 16'h000A; dp_in = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        run_to(64);
        chk("ack_000a",   32'(ack0), 32'h1);
        chk("ackh_000a",  32'(ackh), 32'h1);
        run_to(65);
        chk("a_bcd",      32'(seg0), 32'h00);
        chk("a_hex",      32'(segh), 32'h77);
        chk("a_al_seg",   32'(segl), 32'h08);
        chk("a_al_an",    32'(anl),  32'hE);
        chk("a_al_dp",    32'(dpl),  32'h1);

        // 5. latest load wins; load in the boundary cycle shows a frame later
        din = 16'h1111; load = 1'b1;
        step();
        din = 16'h2222;
        step();
        load = 1'b0;
        run_to(79);
        chk("ack_pre2",   32'(ack0), 32'h0);
        run_to(80);
        chk("ack_2222",   32'(ack0), 32'h1);
        run_to(81);
        chk("ack_once",   32'(ack0), 32'h0);
        chk("d0_2222",    32'(seg0), 32'h6D);
        run_to(90);
        din = 16'h5555; load = 1'b1;
        step();
        load = 1'b0;
        run_to(95);
        din = 16'h3333; load = 1'b1;
        step();
        load = 1'b0;
        chk("ack_5555",   32'(ack0), 32'h1);
        step();
        chk("ack_5555_1", 32'(ack0), 32'h0);
        chk("d0_5555",    32'(seg0), 32'h5B);
        run_to(112);
        chk("ack_3333",   32'(ack0), 32'h1);
        run_to(113);
        chk("d0_3333",    32'(seg0), 32'h79);

        // 6. reset mid-frame with a pending value
        din = 16'h9999; dp_in = 4'b1111; load = 1'b1;
        step();
        load = 1'b0;
        run_to(121);
        rst_n = 1'b0;
        step();
        chk("mid_rst_an",  32'(an0),  32'h0);
        chk("mid_rst_seg", 32'(seg0), 32'h00);
        chk("mid_rst_dp",  32'(dp0),  32'h0);
        chk("mid_rst_ack", 32'(ack0), 32'h0);
        chk("mid_rst_al",  32'(anl),  32'hF);
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        step();
        chk("rel2_an",    32'(an0),  32'h1);
        chk("rel2_seg",   32'(seg0), 32'h7E);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rel2_noack", 32'(ack0), 32'h0);
            if (n == 17) begin
                chk("rel2_d0",    32'(seg0), 32'h7E);
                chk("rel2_d0_dp", 32'(dp0),  32'h0);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
